udp_panel_reader: RTL and testbench

Reads pixels back from the LED panel memories and streams them to the UDP core as one packet per request. It is the transmit-side counterpart of the panel write path. Each pixel goes out as a 4-byte word in the same wire format the writer consumes: addr[13:0], R[5:0], G[5:0], B[5:0], MSB first. Requests come from the control logic; the block sits between the panel memory read ports and the UDP core's transmit sink.

---
 rtl/udp_panel_reader_pkg.sv | 44 ++++
 rtl/udp_panel_reader.sv | 250 +++++++++++++++++++++++++
 tb/tb_udp_panel_reader.sv | 329 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/udp_panel_reader_pkg.sv
// udp_panel_reader_pkg
//   Shared definitions for the LED panel read-back path:
//   - state_t      : reader FSM state encoding (IDLE, FETCH, SEND)
//   - MAX_PIXELS   : largest pixel count per packet (keeps payload <= 1472 B)
//   - pack_pixel   : wire-format pixel word {addr[13:0], R, G, B}, also used
//                    by the panel write path
//   - panel_onehot : panel index (0..5) to one-hot strobe/port pattern
//   - clamp_count  : request count limited to MAX_PIXELS
package udp_panel_reader_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_FETCH,
        ST_SEND
    } state_t;

    localparam int unsigned NUM_PANELS = 6;
    localparam int unsigned MAX_PIXELS = 368;

    function automatic logic [31:0] pack_pixel(
        input logic [13:0] addr,
        input logic [5:0]  red,
        input logic [5:0]  green,
        input logic [5:0]  blue
    );
        return {addr, red, green, blue};
    endfunction

    function automatic logic [5:0] panel_onehot(input logic [2:0] panel);
        logic [5:0] oh;
        oh = '0;
        for (int unsigned i = 0; i < NUM_PANELS; i++) begin
            if (panel == i[2:0]) begin
                oh[i] = 1'b1;
            end
        end
        return oh;
    endfunction

    function automatic logic [8:0] clamp_count(input logic [8:0] count);
        return (count > 9'(MAX_PIXELS)) ? 9'(MAX_PIXELS) : count;
    endfunction

endpackage

// File: rtl/udp_panel_reader.sv
// udp_panel_reader
//   Reads pixels back from the LED panel memories and streams them to the UDP
//   core, one packet per request, 4 bytes per pixel (MSB first) in the
//   {addr[13:0], R, G, B} wire format.
//
// Parameters
//   PORT_MSB    upper byte of the UDP source port
//   RD_LATENCY  cycles from ctrl_rd_en to valid ctrl_rd_data (1..3)
//
// Ports
//   clock, reset            system clock, synchronous active-high reset
//   req_*                   read-back request (valid/ready handshake)
//   ctrl_rd_en/addr/data    panel memory read port (one-hot strobe)
//   udp_sink_*              byte stream + header towards the UDP core
//   busy                    inverse of req_ready
module udp_panel_reader #(
    parameter logic [7:0]  PORT_MSB   = 8'h00,
    parameter int unsigned RD_LATENCY = 1
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [2:0]  req_panel,
    input  logic [13:0] req_addr,
    input  logic [8:0]  req_count,
    input  logic [31:0] req_ip,
    input  logic [15:0] req_port,
    output logic [5:0]  ctrl_rd_en,
    output logic [15:0] ctrl_rd_addr,
    input  logic [23:0] ctrl_rd_data,
    output logic        udp_sink_valid,
    output logic        udp_sink_last,
    input  logic        udp_sink_ready,
    output logic [15:0] udp_sink_src_port,
    output logic [15:0] udp_sink_dst_port,
    output logic [31:0] udp_sink_ip_address,
    output logic [15:0] udp_sink_length,
    output logic [31:0] udp_sink_data,
    output logic        busy
);
    import udp_panel_reader_pkg::*;

    state_t      state_q, state_d;
    logic        req_ready_q, req_ready_d;
    logic        busy_q, busy_d;
    logic [2:0]  panel_q, panel_d;
    logic [5:0]  rd_en_q, rd_en_d;
    logic [13:0] rd_cur_addr_q, rd_cur_addr_d;   // address of the outstanding read
    logic [13:0] rd_next_addr_q, rd_next_addr_d; // address of the next read to issue
    logic [8:0]  to_read_q, to_read_d;           // reads not yet issued
    logic [8:0]  to_send_q, to_send_d;           // pixels not yet fully sent
    logic [2:0]  rd_pipe_q, rd_pipe_d;           // tracks read latency
    logic [31:0] word_q, word_d;
    logic [31:0] next_q, next_d;
    logic        next_valid_q, next_valid_d;
    logic [1:0]  byte_idx_q, byte_idx_d;
    logic        valid_q, valid_d;
    logic        last_q, last_d;
    logic [31:0] data_q, data_d;
    logic [15:0] src_port_q, src_port_d;
    logic [15:0] dst_port_q, dst_port_d;
    logic [31:0] ip_q, ip_d;
    logic [15:0] length_q, length_d;

    logic [8:0]  eff_count;
    logic        data_hit;
    logic        handshake;
    logic [31:0] rd_word;
    logic [7:0]  sel_byte;

    // Pad bits of the read data carry no information.
    logic unused_rd_pad;
    assign unused_rd_pad = ^{ctrl_rd_data[23:22], ctrl_rd_data[15:14], ctrl_rd_data[7:6]};

    assign eff_count = clamp_count(req_count);
    assign data_hit  = rd_pipe_q[RD_LATENCY-1];
    assign handshake = valid_q && udp_sink_ready;
    assign rd_word   = pack_pixel(rd_cur_addr_q, ctrl_rd_data[21:16],
                                  ctrl_rd_data[13:8], ctrl_rd_data[5:0]);

    always_comb begin
        state_d        = state_q;
        req_ready_d    = req_ready_q;
        busy_d         = busy_q;
        panel_d        = panel_q;
        rd_en_d        = '0;
        rd_cur_addr_d  = rd_cur_addr_q;
        rd_next_addr_d = rd_next_addr_q;
        to_read_d      = to_read_q;
        to_send_d      = to_send_q;
        rd_pipe_d      = {rd_pipe_q[1:0], |rd_en_q};
        word_d         = word_q;
        next_d         = next_q;
        next_valid_d   = next_valid_q;
        byte_idx_d     = byte_idx_q;
        valid_d        = valid_q;
        src_port_d     = src_port_q;
        dst_port_d     = dst_port_q;
        ip_d           = ip_q;
        length_d       = length_q;

        unique case (state_q)
            ST_IDLE: begin
                // A zero count is accepted and silently dropped.
                if (req_valid && req_ready_q && (eff_count != '0)) begin
                    panel_d        = req_panel;
                    src_port_d     = {PORT_MSB, 2'b00, panel_onehot(req_panel)};
                    dst_port_d     = req_port;
                    ip_d           = req_ip;
                    length_d       = {5'b0, eff_count, 2'b00};
                    rd_en_d        = panel_onehot(req_panel);
                    rd_cur_addr_d  = req_addr;
                    rd_next_addr_d = req_addr + 14'd1;
                    to_read_d      = eff_count - 9'd1;
                    to_send_d      = eff_count;
                    next_valid_d   = 1'b0;
                    req_ready_d    = 1'b0;
                    busy_d         = 1'b1;
                    state_d        = ST_FETCH;
                end
            end

            // Waits for a read already in flight; never issues one itself.
            ST_FETCH: begin
                if (data_hit) begin
                    word_d     = rd_word;
                    byte_idx_d = 2'd0;
                    valid_d    = 1'b1;
                    state_d    = ST_SEND;
                end
            end

            ST_SEND: begin
                if (data_hit) begin
                    next_d       = rd_word;
                    next_valid_d = 1'b1;
                end
                if (handshake) begin
                    // Prefetch the following pixel on the first byte of this one.
                    if ((byte_idx_q == 2'd0) && (to_read_q != '0)) begin
                        rd_en_d        = panel_onehot(panel_q);
                        rd_cur_addr_d  = rd_next_addr_q;
                        rd_next_addr_d = rd_next_addr_q + 14'd1;
                        to_read_d      = to_read_q - 9'd1;
                    end
                    if (byte_idx_q == 2'd3) begin
                        if (to_send_q == 9'd1) begin
                            valid_d      = 1'b0;
                            next_valid_d = 1'b0;
                            req_ready_d  = 1'b1;
                            busy_d       = 1'b0;
                            state_d      = ST_IDLE;
                        end else begin
                            to_send_d  = to_send_q - 9'd1;
                            byte_idx_d = 2'd0;
                            // Prefer the held prefetch, else take data arriving
                            // this cycle; if neither, drop valid and wait.
                            if (next_valid_q) begin
                                word_d       = next_q;
                                next_valid_d = 1'b0;
                            end else if (data_hit) begin
                                word_d       = rd_word;
                                next_valid_d = 1'b0;
                            end else begin
                                valid_d = 1'b0;
                                state_d = ST_FETCH;
                            end
                        end
                    end else begin
                        byte_idx_d = byte_idx_q + 2'd1;
                    end
                end
            end

            default: state_d = ST_IDLE;
        endcase

        unique case (byte_idx_d)
            2'd0:    sel_byte = word_d[31:24];
            2'd1:    sel_byte = word_d[23:16];
            2'd2:    sel_byte = word_d[15:8];
            default: sel_byte = word_d[7:0];
        endcase

        data_d = valid_d ? {24'b0, sel_byte} : '0;
        last_d = valid_d && (byte_idx_d == 2'd3) && (to_send_d == 9'd1);
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q        <= ST_IDLE;
            req_ready_q    <= 1'b1;
            busy_q         <= 1'b0;
            panel_q        <= '0;
            rd_en_q        <= '0;
            rd_cur_addr_q  <= '0;
            rd_next_addr_q <= '0;
            to_read_q      <= '0;
            to_send_q      <= '0;
            rd_pipe_q      <= '0;
            word_q         <= '0;
            next_q         <= '0;
            next_valid_q   <= 1'b0;
            byte_idx_q     <= '0;
            valid_q        <= 1'b0;
            last_q         <= 1'b0;
            data_q         <= '0;
            src_port_q     <= '0;
            dst_port_q     <= '0;
            ip_q           <= '0;
            length_q       <= '0;
        end else begin
            state_q        <= state_d;
            req_ready_q    <= req_ready_d;
            busy_q         <= busy_d;
            panel_q        <= panel_d;
            rd_en_q        <= rd_en_d;
            rd_cur_addr_q  <= rd_cur_addr_d;
            rd_next_addr_q <= rd_next_addr_d;
            to_read_q      <= to_read_d;
            to_send_q      <= to_send_d;
            rd_pipe_q      <= rd_pipe_d;
            word_q         <= word_d;
            next_q         <= next_d;
            next_valid_q   <= next_valid_d;
            byte_idx_q     <= byte_idx_d;
            valid_q        <= valid_d;
            last_q         <= last_d;
            data_q         <= data_d;
            src_port_q     <= src_port_d;
            dst_port_q     <= dst_port_d;
            ip_q           <= ip_d;
            length_q       <= length_d;
        end
    end

    assign req_ready           = req_ready_q;
    assign busy                = busy_q;
    assign ctrl_rd_en          = rd_en_q;
    assign ctrl_rd_addr        = {2'b00, rd_cur_addr_q};
    assign udp_sink_valid      = valid_q;
    assign udp_sink_last       = last_q;
    assign udp_sink_data       = data_q;
    assign udp_sink_src_port   = src_port_q;
    assign udp_sink_dst_port   = dst_port_q;
    assign udp_sink_ip_address = ip_q;
    assign udp_sink_length     = length_q;

endmodule

// File: tb/tb_udp_panel_reader.sv
// tb_udp_panel_reader
//   Directed bench for udp_panel_reader with a latency-accurate panel memory
//   model and a byte/read-address scoreboard.
module tb_udp_panel_reader;

    localparam logic [7:0]  PMSB   = 8'hA5;
    localparam int unsigned RD_LAT = 2;

    logic        clock;
    logic        reset;
    logic        req_valid;
    logic        req_ready;
    logic [2:0]  req_panel;
    logic [13:0] req_addr;
    logic [8:0]  req_count;
    logic [31:0] req_ip;
    logic [15:0] req_port;
    logic [5:0]  ctrl_rd_en;
    logic [15:0] ctrl_rd_addr;
    logic [23:0] ctrl_rd_data;
    logic        udp_sink_valid;
    logic        udp_sink_last;
    logic        udp_sink_ready;
    logic [15:0] udp_sink_src_port;
    logic [15:0] udp_sink_dst_port;
    logic [31:0] udp_sink_ip_address;
    logic [15:0] udp_sink_length;
    logic [31:0] udp_sink_data;
    logic        busy;

    udp_panel_reader #(.PORT_MSB(PMSB), .RD_LATENCY(RD_LAT)) dut (
        .clock(clock), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready), .req_panel(req_panel),
        .req_addr(req_addr), .req_count(req_count), .req_ip(req_ip), .req_port(req_port),
        .ctrl_rd_en(ctrl_rd_en), .ctrl_rd_addr(ctrl_rd_addr), .ctrl_rd_data(ctrl_rd_data),
        .udp_sink_valid(udp_sink_valid), .udp_sink_last(udp_sink_last),
        .udp_sink_ready(udp_sink_ready), .udp_sink_src_port(udp_sink_src_port),
        .udp_sink_dst_port(udp_sink_dst_port), .udp_sink_ip_address(udp_sink_ip_address),
        .udp_sink_length(udp_sink_length), .udp_sink_data(udp_sink_data), .busy(busy)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // ---------------- memory model ----------------
    logic        use_fixed = 1'b0;
    logic [23:0] fixed_data = 24'h0;

    function automatic logic [23:0] mem_data(input int p, input logic [13:0] a);
        logic [5:0] r, g, b;
        if (use_fixed) return fixed_data;
        r = a[5:0] ^ 6'(p * 9);
        g = a[11:6] + 6'd7;
        b = {a[13:12], a[3:0]} ^ 6'h2A;
        return {2'b00, r, 2'b00, g, 2'b00, b};
    endfunction

    function automatic int oh_idx(input logic [5:0] oh);
        int r;
        r = 0;
        for (int i = 0; i < 6; i++) if (oh[i]) r = i;
        return r;
    endfunction

    logic [23:0] st_d [0:2];
    always @(posedge clock) begin
        st_d[0] <= mem_data(oh_idx(ctrl_rd_en), ctrl_rd_addr[13:0]);
        st_d[1] <= st_d[0];
        st_d[2] <= st_d[1];
    end
    assign ctrl_rd_data = st_d[RD_LAT-1];

    // ---------------- scoreboard state ----------------
    typedef struct packed {
        logic [7:0] b;
        logic       last;
    } beat_t;

    beat_t       exp_q[$];
    logic [21:0] exp_rd_q[$];
    logic [7:0]  obs_q[$];
    logic [13:0] rd_obs_q[$];

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int req_cyc = 0;
    int first_valid_cyc = -1;
    int first_rd_cyc = -1;
    int gaps = 0;
    int beats = 0;
    logic rand_ready = 1'b0;
    logic prev_stall = 1'b0;
    logic prev_rd = 1'b0;
    logic [31:0] prev_data = '0;
    logic prev_last = 1'b0;
    logic [15:0] exp_src, exp_dst, exp_len;
    logic [31:0] exp_ip;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] expv);
        checks++;
        assert (got === expv) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, expv);
        end
    endtask

    task automatic monitor();
        beat_t e;
        logic [21:0] r;
        if (ctrl_rd_en != '0) begin
            chk("rd_while_busy", busy, 1'b1);
            chk("rd_single_pulse", prev_rd, 1'b0);
            if (first_rd_cyc < 0) first_rd_cyc = cyc - req_cyc;
            rd_obs_q.push_back(ctrl_rd_addr[13:0]);
            chk("rd_expected", exp_rd_q.size() != 0, 1'b1);
            if (exp_rd_q.size() != 0) begin
                r = exp_rd_q.pop_front();
                chk("rd_en_addr", {ctrl_rd_en, ctrl_rd_addr}, r);
            end
        end
        prev_rd = (ctrl_rd_en != '0);
        if (prev_stall) begin
            chk("stall_valid", udp_sink_valid, 1'b1);
            chk("stall_data", udp_sink_data, prev_data);
            chk("stall_last", udp_sink_last, prev_last);
        end
        if (udp_sink_valid) begin
            if (first_valid_cyc < 0) first_valid_cyc = cyc - req_cyc;
            if (udp_sink_ready) begin
                chk("beat_expected", exp_q.size() != 0, 1'b1);
                if (exp_q.size() != 0) begin
                    e = exp_q.pop_front();
                    chk("beat_data", udp_sink_data, {24'h0, e.b});
                    chk("beat_last", udp_sink_last, e.last);
                    chk("hdr_src", udp_sink_src_port, exp_src);
                    chk("hdr_dst", udp_sink_dst_port, exp_dst);
                    chk("hdr_ip", udp_sink_ip_address, exp_ip);
                    chk("hdr_len", udp_sink_length, exp_len);
                end
                obs_q.push_back(udp_sink_data[7:0]);
                beats++;
            end
        end else if (first_valid_cyc >= 0 && exp_q.size() != 0) begin
            gaps++;
        end
        prev_stall = udp_sink_valid && !udp_sink_ready;
        prev_data  = udp_sink_data;
        prev_last  = udp_sink_last;
    endtask

    task automatic tick();
        @(negedge clock);
        monitor();
        @(posedge clock);
        #1;
        cyc++;
        if (rand_ready) udp_sink_ready = 1'($urandom_range(0, 1));
    endtask

    task automatic do_request(input logic [2:0] p, input logic [13:0] a, input logic [8:0] c,
                              input logic [31:0] ip, input logic [15:0] port);
        int eff;
        logic [13:0] ad;
        logic [23:0] d;
        logic [31:0] w;
        logic [5:0] oh;
        eff = (c > 9'd368) ? 368 : int'(c);
        oh = 6'b000001 << p;
        if (eff != 0) begin
            exp_src = {PMSB, 2'b00, oh};
            exp_dst = port;
            exp_ip  = ip;
            exp_len = 16'(eff * 4);
        end
        for (int i = 0; i < eff; i++) begin
            ad = a + 14'(i);
            exp_rd_q.push_back({oh, 2'b00, ad});
            d = mem_data(int'(p), ad);
            w = (32'(ad) << 18) | (32'(d[21:16]) << 12) | (32'(d[13:8]) << 6) | 32'(d[5:0]);
            for (int b = 0; b < 4; b++)
                exp_q.push_back('{b: w[31-8*b -: 8], last: (i == eff - 1) && (b == 3)});
        end
        obs_q.delete();
        rd_obs_q.delete();
        req_panel = p; req_addr = a; req_count = c; req_ip = ip; req_port = port;
        req_valid = 1'b1;
        chk("req_ready_at_req", req_ready, 1'b1);
        req_cyc = cyc;
        first_valid_cyc = -1;
        first_rd_cyc = -1;
        gaps = 0;
        beats = 0;
        tick();
        req_valid = 1'b0;
    endtask

    task automatic wait_done(input int budget, input logic timing);
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < budget) begin
            tick();
            n++;
        end
        chk("pkt_timeout", exp_q.size() == 0, 1'b1);
        chk("req_ready_after_last", req_ready, 1'b1);
        chk("busy_after_last", busy, 1'b0);
        chk("reads_all_issued", exp_rd_q.size(), 0);
        if (timing) begin
            chk("first_rd_latency", first_rd_cyc, 1);
            chk("first_valid_latency", first_valid_cyc, 2 + RD_LAT);
            chk("beat_gaps", gaps, 0);
        end
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_req_ready"}, req_ready, 1'b1);
        chk({tag, "_busy"}, busy, 1'b0);
        chk({tag, "_rd_en"}, ctrl_rd_en, 6'h0);
        chk({tag, "_valid"}, udp_sink_valid, 1'b0);
        chk({tag, "_last"}, udp_sink_last, 1'b0);
        chk({tag, "_data"}, udp_sink_data, 32'h0);
        chk({tag, "_src"}, udp_sink_src_port, 16'h0);
        chk({tag, "_len"}, udp_sink_length, 16'h0);
    endtask

    initial begin
        int n;
        reset = 1'b1; req_valid = 1'b0; req_panel = '0; req_addr = '0; req_count = '0;
        req_ip = '0; req_port = '0; udp_sink_ready = 1'b1;
        repeat (3) @(posedge clock);
        #1;
        chk_reset_outputs("reset");
        chk("reset_rd_addr", ctrl_rd_addr, 16'h0);
        chk("reset_ip", udp_sink_ip_address, 32'h0);
        chk("reset_dst", udp_sink_dst_port, 16'h0);
        reset = 1'b0;
        tick();

        // Single pixel with a fixed memory word.
        use_fixed = 1'b1;
        fixed_data = {2'b00, 6'h3F, 2'b00, 6'h00, 2'b00, 6'h15};
        do_request(3'd2, 14'h0010, 9'd1, 32'hC0A8_0102, 16'd5000);
        wait_done(40, 1'b1);
        use_fixed = 1'b0;
        chk("t1_src_port", udp_sink_src_port, 16'hA504);
        chk("t1_length", udp_sink_length, 16'd4);
        chk("t1_nbytes", obs_q.size(), 4);
        if (obs_q.size() == 4) begin
            chk("t1_b0", obs_q[0], 8'h00);
            chk("t1_b1", obs_q[1], 8'h43);
            chk("t1_b2", obs_q[2], 8'hF0);
            chk("t1_b3", obs_q[3], 8'h15);
        end
        tick();

        // Three pixels, ready held high: contiguous beats.
        do_request(3'd4, 14'h0010, 9'd3, 32'h0A00_0001, 16'h1234);
        wait_done(60, 1'b1);
        chk("t2_beats", beats, 12);
        chk("t2_nreads", rd_obs_q.size(), 3);
        if (rd_obs_q.size() == 3) begin
            chk("t2_rd0", rd_obs_q[0], 14'h0010);
            chk("t2_rd1", rd_obs_q[1], 14'h0011);
            chk("t2_rd2", rd_obs_q[2], 14'h0012);
        end

        // Same request under random backpressure, issued right after completion.
        rand_ready = 1'b1;
        do_request(3'd4, 14'h0010, 9'd3, 32'h0A00_0001, 16'h1234);
        wait_done(400, 1'b0);
        chk("t3_beats", beats, 12);
        rand_ready = 1'b0;
        udp_sink_ready = 1'b1;
        tick();

        // Address wrap.
        do_request(3'd0, 14'h3FFE, 9'd3, 32'h0102_0304, 16'd80);
        wait_done(60, 1'b1);
        chk("t4_nreads", rd_obs_q.size(), 3);
        if (rd_obs_q.size() == 3) begin
            chk("t4_rd0", rd_obs_q[0], 14'h3FFE);
            chk("t4_rd1", rd_obs_q[1], 14'h3FFF);
            chk("t4_rd2", rd_obs_q[2], 14'h0000);
        end

        // Zero count: dropped without reads or beats.
        do_request(3'd1, 14'h0100, 9'd0, 32'h1111_1111, 16'd1);
        chk("t5_req_ready_next", req_ready, 1'b1);
        repeat (8) tick();
        chk("t5_no_valid", udp_sink_valid, 1'b0);
        chk("t5_no_beats", beats, 0);
        chk("t5_no_reads", rd_obs_q.size(), 0);

        // Oversized count clamps to 368 pixels.
        do_request(3'd5, 14'h3F00, 9'd400, 32'hDEAD_BEEF, 16'hFFFF);
        wait_done(2000, 1'b1);
        chk("t6_length", udp_sink_length, 16'd1472);
        chk("t6_beats", beats, 1472);
        chk("t6_nreads", rd_obs_q.size(), 368);

        // Reset while byte 5 of 12 is on the bus.
        do_request(3'd3, 14'h0100, 9'd3, 32'h2222_2222, 16'd2);
        n = 0;
        while (beats < 4 && n < 40) begin
            tick();
            n++;
        end
        chk("t7_reached_byte5", beats, 4);
        chk("t7_valid_before_reset", udp_sink_valid, 1'b1);
        reset = 1'b1;
        @(posedge clock);
        #1;
        chk_reset_outputs("t7_after_reset");
        reset = 1'b0;
        exp_q.delete();
        exp_rd_q.delete();
        prev_stall = 1'b0;
        prev_rd = 1'b0;
        tick();
        do_request(3'd1, 14'h0020, 9'd2, 32'h3333_3333, 16'd3);
        wait_done(60, 1'b1);
        chk("t7_new_beats", beats, 8);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
